// File: rtl/keypad_loader_pkg.sv
// Shared definitions for the keypad entry controller: FSM state encoding and
// keypad/BCD sizing.
package keypad_loader_pkg;

  localparam int KL_NUM_KEYS = 10;
  localparam int KL_BCD_W    = 4;

  typedef enum logic [1:0] {
    KL_IDLE         = 2'd0,
    KL_DEBOUNCE     = 2'd1,
    KL_LOAD         = 2'd2,
    KL_WAIT_RELEASE = 2'd3
  } kl_state_e;

endpackage

// File: rtl/keypad_loader_key_encoder.sv
// One-hot decimal key vector to BCD, plus a flag that exactly one key is set.
// Shared with the display and door-panel logic.
module keypad_loader_key_encoder
  import keypad_loader_pkg::*;
(
  input  logic [KL_NUM_KEYS-1:0] onehot_i,
  output logic [KL_BCD_W-1:0]    bcd_o,
  output logic                   valid_o
);

  // OR of indices is exact whenever the input is one-hot; other inputs are
  // flagged invalid and their BCD value is don't-care.
  always_comb begin
    bcd_o = '0;
    for (int i = 0; i < KL_NUM_KEYS; i++) begin
      if (onehot_i[i]) bcd_o = bcd_o | KL_BCD_W'(i);
    end
    valid_o = $onehot(onehot_i);
  end

endmodule

// File: rtl/keypad_loader.sv
// Microwave keypad entry controller: debounces digit and CLEAR keys and drives
// the countdown timer's digit load and clear strobes.
//
// state           | meaning
// KL_IDLE         | waiting for a single-key press while unlocked
// KL_DEBOUNCE     | key held stable, counting towards acceptance
// KL_LOAD         | committed cycle that issues the load strobe
// KL_WAIT_RELEASE | waiting for all keys released for the debounce time
module keypad_loader
  import keypad_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3
) (
  input  logic                   CLK,
  input  logic                   clearn,
  input  logic [KL_NUM_KEYS-1:0] keys,
  input  logic                   clr_key,
  input  logic                   lock,
  output logic [KL_BCD_W-1:0]    digit,
  output logic                   loadn,
  output logic                   timer_clearn,
  output logic [1:0]             digits_entered,
  output logic                   busy
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [1:0]       DIG_MAX  = 2'(MAX_DIGITS);

  kl_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
  logic [KL_NUM_KEYS-1:0]     key_q, key_d;
  logic [KL_BCD_W-1:0]        bcd_q, bcd_d;
  logic [KL_BCD_W-1:0]        digit_q, digit_d;
  logic                       clr_q;
  logic                       loadn_q, loadn_d;
  logic                       tclrn_q, tclrn_d;
  logic [1:0]                 dig_cnt_q, dig_cnt_d;
  logic                       busy_q, busy_d;
  logic [KL_BCD_W-1:0]        key_bcd;
  logic                       key_valid;
  logic                       clr_rise;

  keypad_loader_key_encoder u_key_enc (
    .onehot_i (keys),
    .bcd_o    (key_bcd),
    .valid_o  (key_valid)
  );

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign clr_rise = clr_key & ~clr_q;

  always_ff @(posedge CLK or negedge clearn) begin
    if (!clearn) begin
      state_q   <= KL_IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      bcd_q     <= '0;
      digit_q   <= '0;
      clr_q     <= 1'b0;
      loadn_q   <= 1'b1;
      tclrn_q   <= 1'b1;
      dig_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      bcd_q     <= bcd_d;
      digit_q   <= digit_d;
      clr_q     <= clr_key;
      loadn_q   <= loadn_d;
      tclrn_q   <= tclrn_d;
      dig_cnt_q <= dig_cnt_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    bcd_d     = bcd_q;
    digit_d   = digit_q;
    loadn_d   = 1'b1;
    tclrn_d   = 1'b1;
    dig_cnt_d = dig_cnt_q;

    case (state_q)
      KL_IDLE: begin
        if (!lock && key_valid) begin
          key_d   = keys;
          bcd_d   = key_bcd;
          cnt_d   = CNT_W'(1);
          state_d = KL_DEBOUNCE;
        end
      end
      KL_DEBOUNCE: begin
        if (lock || keys != key_q) begin
          state_d = KL_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_DONE) begin
            if (dig_cnt_q < DIG_MAX) begin
              state_d = KL_LOAD;
            end else begin
              state_d = KL_WAIT_RELEASE;
              cnt_d   = '0;
            end
          end
        end
      end
      KL_LOAD: begin
        loadn_d   = 1'b0;
        digit_d   = bcd_q;
        dig_cnt_d = (dig_cnt_q == DIG_MAX) ? dig_cnt_q : dig_cnt_q + 2'd1;
        cnt_d     = '0;
        state_d   = KL_WAIT_RELEASE;
      end
      KL_WAIT_RELEASE: begin
        if (keys == '0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_DONE) state_d = KL_IDLE;
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = KL_IDLE;
    endcase

    // CLEAR overrides everything, including a committed load.
    if (clr_rise) begin
      tclrn_d   = 1'b0;
      loadn_d   = 1'b1;
      digit_d   = digit_q;
      dig_cnt_d = '0;
      cnt_d     = '0;
      state_d   = KL_WAIT_RELEASE;
    end

    busy_d = (state_d != KL_IDLE);
  end

  assign digit          = digit_q;
  assign loadn          = loadn_q;
  assign timer_clearn   = tclrn_q;
  assign digits_entered = dig_cnt_q;
  assign busy           = busy_q;

endmodule

// File: doc/keypad_loader.md
Name: keypad_loader

Overview:
- Entry-side controller for the microwave countdown timer.
- Debounces a 10-key decimal keypad plus a CLEAR key, and encodes each accepted press to BCD.
- Issues a one-cycle active-low load strobe with the digit, so digits shift into secs → tens_secs → minutes.
- Pulses the timer's clear line on CLEAR, caps entry at MAX_DIGITS, and ignores keys while the oven is cooking (lock).

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable CLK cycles required to accept a press or a release.
- MAX_DIGITS, 3, digits accepted before further digit keys are ignored until CLEAR.

Ports:
- CLK  input  1  block clock, shared with the timer load path.
- clearn  input  1  reset; asynchronous, active-low.
- keys  input  10  raw digit keys; keys[i] high = key i pressed.
- clr_key  input  1  raw CLEAR key, active-high.
- lock  input  1  high while cooking; digit entry is inhibited.
- digit  output  4  BCD of the last accepted key; feeds the timer digit input.
- loadn  output  1  active-low load strobe, exactly one CLK cycle per accepted digit.
- timer_clearn  output  1  active-low one-cycle clear pulse to the timer.
- digits_entered  output  2  count of digits loaded since the last CLEAR or reset (0..MAX_DIGITS).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (clearn low, async):
  - State is IDLE.
  - digit=0, loadn=1, timer_clearn=1, digits_entered=0, busy=0.
  - Debounce counter=0; clr_key history register=0.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Valid press: keys has exactly one bit set. Zero keys or two or more keys is not a press.
- FSM states:
  - IDLE:
    - If lock=0 and keys is a valid press, capture keys into key_q, set cnt=1, go to DEBOUNCE.
    - Otherwise stay in IDLE.
  - DEBOUNCE:
    - If lock=1 or keys≠key_q, go to IDLE with no load.
    - Else cnt++. When cnt reaches DEBOUNCE_CYCLES, go to LOAD if digits_entered<MAX_DIGITS, else go to WAIT_RELEASE (press swallowed).
  - LOAD:
    - Exactly one cycle: loadn=0, digit=encode(key_q), digits_entered++.
    - Next state is WAIT_RELEASE with cnt=0.
    - digit holds its value after loadn returns high.
  - WAIT_RELEASE:
    - When keys==0, cnt++; any nonzero keys sets cnt=0.
    - When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
    - A held key never produces a second load (no auto-repeat).
- Timing:
  - Latency from first stable press cycle to loadn low is DEBOUNCE_CYCLES+1 CLK edges.
  - digit is valid on the same edge that loadn falls.
- CLEAR:
  - clr_key is rising-edge detected against a registered copy.
  - On the rise: timer_clearn=0 for exactly one cycle, digits_entered=0, and the FSM is forced to WAIT_RELEASE with cnt=0.
  - CLEAR has priority over every state, including LOAD. If both occur in the same cycle, no load strobe is issued.
  - CLEAR is accepted regardless of lock.
  - A CLEAR held high does not re-pulse timer_clearn.
- lock:
  - lock rising during DEBOUNCE aborts the press.
  - The LOAD cycle, being already committed, completes.
  - lock has no effect in WAIT_RELEASE.
- digits_entered saturates at MAX_DIGITS; it never wraps.
- Encoder: keys[i] → digit=i, for i in 0..9. key_q is always one-hot, so no priority logic is needed.
- Asserting clearn mid-sequence returns to reset values immediately, including releasing a low loadn.

Decomposition:
- Shared header (keypad_defs):
  - State encodings KL_IDLE, KL_DEBOUNCE, KL_LOAD, KL_WAIT_RELEASE (2-bit).
  - Key count constant 10.
  - BCD width constant 4.
- Sub-module key_encoder: combinational one-hot-10 to BCD plus an onehot_valid flag. It is reused by the display and door-panel logic.
- The debounce counter stays inline, sized $clog2(DEBOUNCE_CYCLES+1).

Test Plan (DEBOUNCE_CYCLES=4, MAX_DIGITS=3):
- Press 5: hold keys=10'b0000100000 for 6 cycles, then release for 5 cycles → exactly one loadn=0 pulse with digit=5 on the 5th edge after the press; digits_entered=1; back in IDLE.
- Bounce: keys toggle between key 3 and 0 every 2 cycles for 10 cycles, then settle at 0 → no loadn pulse; busy returns to 0.
- Entry cap: press 1, then 2, then 0, then 7, each press and release clean → three loads (1, 2, 0); the 7 press is swallowed; digits_entered=3.
- CLEAR: from digits_entered=3, raise clr_key for 3 cycles → one timer_clearn=0 pulse; digits_entered=0; a following press of 4 loads digit=4.
- Lock/multi-key: lock=1 while pressing 9 gives no load. With lock=0, pressing keys 2 and 6 together gives no load. Raising lock in the 2nd DEBOUNCE cycle aborts the press to IDLE.
- Reset: assert clearn on the LOAD cycle → loadn returns to 1 asynchronously; all outputs at reset values; CLEAR and load arriving in the same cycle yield timer_clearn=0 and no loadn pulse.
